// File: rtl/mult_div_unit.sv
// Iterative 32-cycle multiply/divide unit with architectural HI/LO registers.
// Multiply is shift-add on magnitudes; divide is restoring shift-subtract on magnitudes.
// Signs are fixed up in a final cycle.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [1:0]       op,
  input  logic             start,
  input  logic             hiWe,
  input  logic             loWe,
  input  logic [WIDTH-1:0] wrData,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_t;

  state_t             state, stateNext;
  logic [CntW-1:0]    count;
  logic               isDiv, negRes, negRem, divZero;
  logic [WIDTH-1:0]   operand;   // multiplicand magnitude or divisor magnitude
  logic [WIDTH-1:0]   origA;     // raw dividend, returned in HI on divide by zero
  logic [2*WIDTH-1:0] acc;       // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   hiReg, loReg;
  logic               doneReg;

  logic               signA, signB;
  logic [WIDTH-1:0]   absA, absB;
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulNext;
  logic [WIDTH:0]     remShift, remNew;
  logic               canSub;
  logic [2*WIDTH-1:0] divNext;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quotFix, remFix;
  logic [WIDTH-1:0]   finHi, finLo;

  assign busy = (state != StIdle);
  assign done = doneReg;
  assign hi   = hiReg;
  assign lo   = loReg;

  // Operand magnitudes; op[0]=0 selects the signed variants. abs(0x80000000) stays 2^31.
  always_comb begin
    signA = ~op[0] & opA[WIDTH-1];
    signB = ~op[0] & opB[WIDTH-1];
    absA  = signA ? (~opA + 1'b1) : opA;
    absB  = signB ? (~opB + 1'b1) : opB;
  end

  // One iteration of shift-add and of restoring shift-subtract.
  always_comb begin
    mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    mulNext  = {mulSum, acc[WIDTH-1:1]};
    remShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    canSub   = (remShift >= {1'b0, operand});
    remNew   = canSub ? (remShift - {1'b0, operand}) : remShift;
    divNext  = {remNew[WIDTH-1:0], acc[WIDTH-2:0], canSub};
  end

  // Sign correction and final result selection.
  always_comb begin
    prodFix = negRes ? (~acc + 1'b1) : acc;
    quotFix = negRes ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    remFix  = negRem ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    finHi   = prodFix[2*WIDTH-1:WIDTH];
    finLo   = prodFix[WIDTH-1:0];
    if (isDiv) begin
      if (divZero) begin
        finHi = origA;
        finLo = '1;
      end else begin
        finHi = remFix;
        finLo = quotFix;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= StIdle;
    end else begin
      state <= stateNext;
    end
  end

  // FSM next-state logic.
  always_comb begin
    stateNext = state;
    case (state)
      StIdle:  if (start) stateNext = StRun;
      StRun:   if (count == LastCnt) stateNext = StFin;
      StFin:   stateNext = StIdle;
      default: stateNext = StIdle;
    endcase
  end

  // Datapath, HI/LO and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      isDiv   <= 1'b0;
      negRes  <= 1'b0;
      negRem  <= 1'b0;
      divZero <= 1'b0;
      operand <= '0;
      origA   <= '0;
      acc     <= '0;
      hiReg   <= '0;
      loReg   <= '0;
      doneReg <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      case (state)
        StIdle: begin
          if (start) begin
            isDiv   <= op[1];
            negRes  <= signA ^ signB;
            negRem  <= signA;
            divZero <= (opB == '0);
            origA   <= opA;
            count   <= '0;
            acc     <= {{WIDTH{1'b0}}, (op[1] ? absA : absB)};
            operand <= op[1] ? absB : absA;
          end else begin
            if (hiWe) hiReg <= wrData;
            if (loWe) loReg <= wrData;
          end
        end
        StRun: begin
          acc   <= isDiv ? divNext : mulNext;
          count <= count + 1'b1;
        end
        StFin: begin
          hiReg   <= finHi;
          loReg   <= finLo;
          doneReg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random ops
// checked against an arithmetic reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, hiWe, loWe;
  logic [1:0]  op;
  logic [31:0] opA, opB, wrData, hi, lo;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  // Model of the architectural HI/LO contents.
  logic [31:0] curHi = '0;
  logic [31:0] curLo = '0;

  logic [1:0]  ro;
  logic [31:0] ra, rb, eh, el, wd;
  logic        wh, wl;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .opA    (opA),
    .opB    (opB),
    .op     (op),
    .start  (start),
    .hiWe   (hiWe),
    .loWe   (loWe),
    .wrData (wrData),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy),
    .done   (done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // MIPS-style results from plain signed/unsigned arithmetic.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    h = '0;
    l = '0;
    case (o)
      2'd0: begin
        p = 64'(sa * sb);
        h = p[63:32];
        l = p[31:0];
      end
      2'd1: begin
        p = {32'b0, a} * {32'b0, b};
        h = p[63:32];
        l = p[31:0];
      end
      default: begin
        if (b == 0) begin
          l = 32'hFFFF_FFFF;
          h = a;
        end else if (o == 2'd2) begin
          q = sa / sb;
          r = sa % sb;
          l = q[31:0];
          h = r[31:0];
        end else begin
          l = a / b;
          h = a % b;
        end
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h1;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge; leaves the bench at the negedge after the start edge.
  task automatic startOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op    = o;
    opA   = a;
    opB   = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op    = 2'($urandom);
    opA   = $urandom;
    opB   = $urandom;
    check("busy_after_start", {63'b0, busy}, 64'd1);
    check("done_after_start", {63'b0, done}, 64'd0);
  endtask

  // Waits for done (bounded), checks HI/LO hold during the run, busy length and result.
  // injectAt >= 0 pulses start and hiWe mid-operation; both must be ignored.
  task automatic waitDone(input string tag, input logic [31:0] expHi, input logic [31:0] expLo,
                          input int injectAt);
    int busyCnt = 1;
    int n = 0;
    while (!done && n < 60) begin
      check({tag, "_hold_hi"}, {32'b0, hi}, {32'b0, curHi});
      check({tag, "_hold_lo"}, {32'b0, lo}, {32'b0, curLo});
      if (n == injectAt) begin
        start  = 1'b1;
        hiWe   = 1'b1;
        wrData = 32'h1234;
        opA    = 32'd55;
        opB    = 32'd3;
        op     = 2'd1;
      end
      @(negedge clk);
      n++;
      start = 1'b0;
      hiWe  = 1'b0;
      if (busy) busyCnt++;
    end
    if (!done) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      check({tag, "_busy_cycles"}, 64'(busyCnt), 64'd33);
      check({tag, "_hi"}, {32'b0, hi}, {32'b0, expHi});
      check({tag, "_lo"}, {32'b0, lo}, {32'b0, expLo});
      curHi = expHi;
      curLo = expLo;
    end
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    hiWe   = 1'b0;
    loWe   = 1'b0;
    op     = 2'd0;
    opA    = '0;
    opB    = '0;
    wrData = '0;
    repeat (2) @(negedge clk);
    check("reset_hi", {32'b0, hi}, 64'd0);
    check("reset_lo", {32'b0, lo}, 64'd0);
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_done", {63'b0, done}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // MULTU max * max
    startOp(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitDone("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, -1);
    @(negedge clk);
    check("done_one_cycle", {63'b0, done}, 64'd0);

    // MULT -3*5, then DIV -7/2 started in the done cycle
    startOp(2'd0, 32'hFFFF_FFFD, 32'd5);
    waitDone("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFF1, -1);
    startOp(2'd2, 32'hFFFF_FFF9, 32'd2);
    waitDone("div_b2b", 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1);

    // Divide corners
    startOp(2'd3, 32'h64, 32'h0);
    waitDone("divu_zero", 32'h64, 32'hFFFF_FFFF, -1);
    startOp(2'd2, 32'hFFFF_FFF0, 32'h0);
    waitDone("div_zero_neg", 32'hFFFF_FFF0, 32'hFFFF_FFFF, -1);
    startOp(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    waitDone("div_ovf", 32'h0, 32'h8000_0000, -1);

    // Mid-operation start and hiWe are ignored
    startOp(2'd3, 32'd1000, 32'd7);
    waitDone("midop", 32'd6, 32'd142, 9);

    // Reset mid-operation
    @(negedge clk);
    startOp(2'd1, 32'd3, 32'd4);
    repeat (13) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {63'b0, busy}, 64'd0);
    check("abort_hi", {32'b0, hi}, 64'd0);
    check("abort_lo", {32'b0, lo}, 64'd0);
    curHi = '0;
    curLo = '0;
    for (int i = 0; i < 40; i++) begin
      check("abort_no_done", {63'b0, done}, 64'd0);
      @(negedge clk);
    end
    startOp(2'd1, 32'd3, 32'd4);
    waitDone("after_abort", 32'd0, 32'd12, -1);
    @(negedge clk);

    // Direct writes while idle
    hiWe   = 1'b1;
    wrData = 32'hCAFE_BABE;
    @(negedge clk);
    hiWe = 1'b0;
    check("mthi_hi", {32'b0, hi}, 64'hCAFE_BABE);
    check("mthi_lo", {32'b0, lo}, {32'b0, curLo});
    check("mthi_done", {63'b0, done}, 64'd0);
    curHi = 32'hCAFE_BABE;
    hiWe   = 1'b1;
    loWe   = 1'b1;
    wrData = 32'h0BAD_F00D;
    @(negedge clk);
    hiWe = 1'b0;
    loWe = 1'b0;
    check("mthilo_hi", {32'b0, hi}, 64'h0BAD_F00D);
    check("mthilo_lo", {32'b0, lo}, 64'h0BAD_F00D);
    check("mthilo_done", {63'b0, done}, 64'd0);
    curHi = 32'h0BAD_F00D;
    curLo = 32'h0BAD_F00D;

    // hiWe together with start: start wins
    hiWe   = 1'b1;
    wrData = 32'hDEAD_BEEF;
    startOp(2'd1, 32'd2, 32'd3);
    hiWe = 1'b0;
    check("start_wins_hi", {32'b0, hi}, {32'b0, curHi});
    waitDone("start_wins", 32'd0, 32'd6, -1);

    // Random operations, sometimes back-to-back, with random direct writes between
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      ra = pick();
      rb = pick();
      model(ro, ra, rb, eh, el);
      startOp(ro, ra, rb);
      waitDone("rand", eh, el, -1);
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        check("rand_done_width", {63'b0, done}, 64'd0);
        wh     = 1'($urandom);
        wl     = 1'($urandom);
        wd     = $urandom;
        hiWe   = wh;
        loWe   = wl;
        wrData = wd;
        @(negedge clk);
        hiWe = 1'b0;
        loWe = 1'b0;
        if (wh) curHi = wd;
        if (wl) curLo = wd;
        check("rand_wr_hi", {32'b0, hi}, {32'b0, curHi});
        check("rand_wr_lo", {32'b0, lo}, {32'b0, curLo});
        check("rand_wr_done", {63'b0, done}, 64'd0);
      end
    end
    @(negedge clk);
    check("final_idle_busy", {63'b0, busy}, 64'd0);
    check("final_idle_done", {63'b0, done}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes the two register read operands and performs MULT/MULTU/DIV/DIVU over 33 cycles.
- Results go into internal HI/LO registers. The datapath reads them later, and the control unit uses busy to stall HI/LO accesses.
- HI/LO can also be written directly (MTHI/MTLO).

Parameters:
- WIDTH, 32, operand and HI/LO width; only 32 is verified.

Ports:
- clk  input  1  system clock; all state updates on the posedge.
- rst  input  1  synchronous, active-high reset.
- opA  input  WIDTH  multiplicand or dividend (from register read port 1).
- opB  input  WIDTH  multiplier or divisor (from register read port 2).
- op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- start  input  1  request to begin an operation; sampled on the posedge.
- hiWe  input  1  write wrData into HI (MTHI).
- loWe  input  1  write wrData into LO (MTLO).
- wrData  input  WIDTH  data for hiWe/loWe.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse: new hi/lo are valid this cycle.

Behaviour:
- Reset (clk edge with rst=1): state=IDLE, hi=0, lo=0, done=0, counter=0. Reset overrides every other input, including mid-operation; an aborted operation leaves no trace.
- FSM states are IDLE, RUN and FIN. busy = (state != IDLE) and is decoded straight from the state register.
- IDLE, start=1: at that edge (E0), latch op.
  - Signed ops latch |opA| and |opB| and record the result signs. Quotient sign = signA^signB; remainder sign = signA; product sign = signA^signB.
  - Clear the counter and go to RUN.
- RUN: one iteration per edge, for 32 edges (E1..E32); counter counts 0..31. After counter=31, go to FIN.
  - Multiply: shift-add, one multiplier bit per cycle, into a 64-bit accumulator.
  - Divide: restoring shift-subtract, one quotient bit per cycle.
- FIN: at edge E33, apply sign correction (two's-complement negate where the sign is set) and write the results.
  - Multiply: hi = product[63:32], lo = product[31:0].
  - Divide: lo = quotient, hi = remainder.
  - Then go to IDLE and drive done=1 for exactly the one cycle after E33.
- Latency: the start edge plus 33 edges. busy is high for 33 cycles. The next start is accepted in the cycle done is high, i.e. back-to-back operations are allowed.
- Divide by zero (opB=0), signed or unsigned: lo = 32'hFFFFFFFF, hi = opA (original, uncorrected value). The operation still takes the full latency.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): lo = 32'h80000000, hi = 0. No exception.
- Arithmetic details:
  - The abs() of 0x80000000 is treated as unsigned 2^31.
  - The product is a full 64-bit result with no truncation.
  - The remainder satisfies |rem| < |divisor| and has the dividend's sign (zero remainder stays 0).
- start while busy: ignored; the in-flight operation is unaffected.
- hiWe/loWe:
  - Honoured only in IDLE with start=0; hi/lo update at that edge.
  - hiWe and loWe together write both registers.
  - Ignored while busy, and ignored if start=1 in the same cycle (start wins).
- hi/lo hold their values between writes. During RUN, hi/lo keep the previous result; intermediates live in separate registers.
- opA/opB/op may change after E0 without effect.
- done is never asserted except after FIN. done is not asserted for hiWe/loWe writes.

Test Plan:
- MULTU opA=0xFFFFFFFF, opB=0xFFFFFFFF, start=1 for one cycle:
  - busy is high for 33 cycles.
  - done pulses once.
  - hi=0xFFFFFFFE, lo=0x00000001.
- MULT opA=0xFFFFFFFD (-3), opB=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then DIV opA=0xFFFFFFF9 (-7), opB=2, started in the done cycle -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Divide corner cases:
  - DIVU opA=0x64, opB=0 -> lo=0xFFFFFFFF, hi=0x00000064.
  - DIV opA=0x80000000, opB=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Mid-operation inputs: start a DIVU 1000/7, then 10 cycles later pulse start with different operands and assert hiWe with wrData=0x1234. Second start and write are ignored; result is lo=142, hi=6, latency unchanged.
- Reset mid-operation: MULTU 3*4, assert rst for one cycle at cycle 15 -> next cycle busy=0, hi=lo=0, no done pulse. A following MULTU 3*4 gives lo=12, hi=0.
- Direct writes while idle:
  - hiWe=1, wrData=0xCAFEBABE -> hi updates next cycle, lo unchanged, done stays 0.
  - hiWe=1 with start=1 -> the operation starts and hi is not written by wrData.
